// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select generation and load-use hazard detection.
// Optional statistics counters are enabled with FWD_HAZARD_STAT_EN.
module fwd_hazard_ctrl #(
  parameter int NREG_BIT        = 5,
  parameter int MUX_FWD_RF_NBIT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pl_freeze,
  input  logic                       flush,
  input  logic                       id_valid,
  input  logic [NREG_BIT-1:0]        id_rf_ra,
  input  logic [NREG_BIT-1:0]        id_rf_rb,
  input  logic                       id_use_a,
  input  logic                       id_use_b,
  input  logic [NREG_BIT-1:0]        id_rf_wa,
  input  logic                       id_rf_we,
  input  logic                       id_is_load,
  output logic                       id_stall,
  output logic                       ex_bubble,
  output logic [MUX_FWD_RF_NBIT-1:0] mux_fwd_rf_a,
  output logic [MUX_FWD_RF_NBIT-1:0] mux_fwd_rf_b
`ifdef FWD_HAZARD_STAT_EN
  ,
  output logic [31:0]                stat_stall_cnt,
  output logic [31:0]                stat_fwd_cnt
`endif
);

  localparam logic [MUX_FWD_RF_NBIT-1:0] SEL_NORM = MUX_FWD_RF_NBIT'(0);
  localparam logic [MUX_FWD_RF_NBIT-1:0] SEL_TMP  = MUX_FWD_RF_NBIT'(1);
  localparam logic [MUX_FWD_RF_NBIT-1:0] SEL_DAT  = MUX_FWD_RF_NBIT'(2);

  logic                ex_v, ex_we, ex_ld;
  logic [NREG_BIT-1:0] ex_wa;
  logic                ma_v, ma_we;
  logic [NREG_BIT-1:0] ma_wa;

  logic [NREG_BIT-1:0]        src_r [2];
  logic [1:0]                 src_use;
  logic [1:0]                 hit_e;
  logic [1:0]                 hit_m;
  logic [MUX_FWD_RF_NBIT-1:0] sel_next [2];
  logic                       load_ex;

  assign src_r[0] = id_rf_ra;
  assign src_r[1] = id_rf_rb;
  assign src_use  = {id_use_b, id_use_a};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op
      assign hit_e[gi] = ex_v & ex_we & (ex_wa != '0) & (ex_wa == src_r[gi]);
      assign hit_m[gi] = ma_v & ma_we & (ma_wa != '0) & (ma_wa == src_r[gi]);
      // The EX producer is younger than MA, so it takes priority.
      assign sel_next[gi] = !src_use[gi]            ? SEL_NORM :
                            (hit_e[gi] & !ex_ld)    ? SEL_TMP  :
                            hit_m[gi]               ? SEL_DAT  : SEL_NORM;
    end
  endgenerate

  assign id_stall = id_valid & !flush & !pl_freeze & ex_ld & (|(src_use & hit_e));
  assign load_ex  = id_valid & !flush & !id_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v         <= 1'b0;
      ex_we        <= 1'b0;
      ex_ld        <= 1'b0;
      ex_wa        <= '0;
      ma_v         <= 1'b0;
      ma_we        <= 1'b0;
      ma_wa        <= '0;
      mux_fwd_rf_a <= SEL_NORM;
      mux_fwd_rf_b <= SEL_NORM;
      ex_bubble    <= 1'b1;
    end else if (!pl_freeze) begin
      ma_v  <= ex_v;
      ma_we <= ex_we;
      ma_wa <= ex_wa;
      if (load_ex) begin
        ex_v         <= 1'b1;
        ex_we        <= id_rf_we;
        ex_ld        <= id_is_load;
        ex_wa        <= id_rf_wa;
        mux_fwd_rf_a <= sel_next[0];
        mux_fwd_rf_b <= sel_next[1];
        ex_bubble    <= 1'b0;
      end else begin
        ex_v         <= 1'b0;
        ex_we        <= 1'b0;
        ex_ld        <= 1'b0;
        ex_wa        <= '0;
        mux_fwd_rf_a <= SEL_NORM;
        mux_fwd_rf_b <= SEL_NORM;
        ex_bubble    <= 1'b1;
      end
    end
  end

`ifdef FWD_HAZARD_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_cnt <= '0;
      stat_fwd_cnt   <= '0;
    end else if (!pl_freeze) begin
      if (id_stall)
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      if (load_ex && ((sel_next[0] != SEL_NORM) || (sel_next[1] != SEL_NORM)))
        stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl; stat counters checked when FWD_HAZARD_STAT_EN is set.
module tb_fwd_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       pl_freeze;
  logic       flush;
  logic       id_valid;
  logic [4:0] id_rf_ra;
  logic [4:0] id_rf_rb;
  logic       id_use_a;
  logic       id_use_b;
  logic [4:0] id_rf_wa;
  logic       id_rf_we;
  logic       id_is_load;
  logic       id_stall;
  logic       ex_bubble;
  logic [1:0] mux_fwd_rf_a;
  logic [1:0] mux_fwd_rf_b;
`ifdef FWD_HAZARD_STAT_EN
  logic [31:0] stat_stall_cnt;
  logic [31:0] stat_fwd_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fwd_hazard_ctrl #(.NREG_BIT(5), .MUX_FWD_RF_NBIT(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pl_freeze    (pl_freeze),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_rf_ra     (id_rf_ra),
    .id_rf_rb     (id_rf_rb),
    .id_use_a     (id_use_a),
    .id_use_b     (id_use_b),
    .id_rf_wa     (id_rf_wa),
    .id_rf_we     (id_rf_we),
    .id_is_load   (id_is_load),
    .id_stall     (id_stall),
    .ex_bubble    (ex_bubble),
    .mux_fwd_rf_a (mux_fwd_rf_a),
    .mux_fwd_rf_b (mux_fwd_rf_b)
`ifdef FWD_HAZARD_STAT_EN
    ,
    .stat_stall_cnt (stat_stall_cnt),
    .stat_fwd_cnt   (stat_fwd_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic id_set(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                        input logic ua, input logic ub, input logic [4:0] wa,
                        input logic we, input logic ld);
    id_valid = v; id_rf_ra = ra; id_rf_rb = rb; id_use_a = ua; id_use_b = ub;
    id_rf_wa = wa; id_rf_we = we; id_is_load = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    id_set(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0; pl_freeze = 1'b0; flush = 1'b0;
    id_set(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_sel_a", mux_fwd_rf_a, 0);
    chk("rst_sel_b", mux_fwd_rf_b, 0);
    chk("rst_bubble", ex_bubble, 1);
    chk("rst_stall", id_stall, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_bubble", ex_bubble, 1);

    // ALU r3 then immediate consumer on A
    id_set(1, 0, 0, 0, 0, 3, 1, 0);
    tick();
    chk("alu_prod_bubble", ex_bubble, 0);
    id_set(1, 3, 4, 1, 1, 0, 0, 0);
    chk("alu_use_stall", id_stall, 0);
    tick();
    chk("tmp_sel_a", mux_fwd_rf_a, 1);
    chk("tmp_sel_b", mux_fwd_rf_b, 0);
    drain();

    // ALU r3, unrelated, consumer on B
    id_set(1, 0, 0, 0, 0, 3, 1, 0);
    tick();
    id_set(1, 1, 2, 1, 1, 9, 1, 0);
    tick();
    chk("unrel_sel_b", mux_fwd_rf_b, 0);
    id_set(1, 0, 3, 1, 1, 0, 0, 0);
    tick();
    chk("dat_sel_b", mux_fwd_rf_b, 2);
    chk("dat_sel_a_r0", mux_fwd_rf_a, 0);
    drain();

    // Load r5 then immediate consumer on A
    id_set(1, 0, 0, 0, 0, 5, 1, 1);
    tick();
    id_set(1, 5, 6, 1, 1, 0, 0, 0);
    chk("ld_stall_on", id_stall, 1);
    tick();
    chk("ld_bubble", ex_bubble, 1);
    chk("ld_bubble_sel_a", mux_fwd_rf_a, 0);
    chk("ld_stall_off", id_stall, 0);
    tick();
    chk("ld_dat_sel_a", mux_fwd_rf_a, 2);
    chk("ld_no_bubble", ex_bubble, 0);
`ifdef FWD_HAZARD_STAT_EN
    chk("stat_stall_1", stat_stall_cnt, 1);
    chk("stat_fwd_3", stat_fwd_cnt, 3);
`endif
    drain();

    // Two producers of r7, younger wins; r0 never forwards
    id_set(1, 0, 0, 0, 0, 7, 1, 0);
    tick();
    id_set(1, 0, 0, 0, 0, 7, 1, 0);
    tick();
    id_set(1, 7, 0, 1, 0, 0, 0, 0);
    tick();
    chk("younger_tmp_a", mux_fwd_rf_a, 1);
    id_set(1, 0, 0, 0, 0, 0, 1, 0);
    tick();
    id_set(1, 0, 0, 1, 1, 0, 0, 0);
    tick();
    chk("r0_sel_a", mux_fwd_rf_a, 0);
    chk("r0_sel_b", mux_fwd_rf_b, 0);
    drain();

    // Load-use hazard coincident with flush
    id_set(1, 0, 0, 0, 0, 5, 1, 1);
    tick();
    flush = 1'b1;
    id_set(1, 5, 0, 1, 0, 0, 0, 0);
    chk("flush_stall", id_stall, 0);
    tick();
    flush = 1'b0;
    chk("flush_bubble", ex_bubble, 1);
    chk("flush_sel_a", mux_fwd_rf_a, 0);
    chk("flush_sel_b", mux_fwd_rf_b, 0);
    drain();

    // Load-use hazard under freeze for 3 edges
    id_set(1, 0, 0, 0, 0, 5, 1, 1);
    tick();
    pl_freeze = 1'b1;
    id_set(1, 5, 0, 1, 0, 0, 0, 0);
    chk("frz_stall", id_stall, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_hold_bubble", ex_bubble, 0);
      chk("frz_hold_sel_a", mux_fwd_rf_a, 0);
    end
    pl_freeze = 1'b0;
    #1;
    chk("unfrz_stall", id_stall, 1);
    tick();
    chk("unfrz_bubble", ex_bubble, 1);
    chk("unfrz_stall_off", id_stall, 0);
    tick();
    chk("unfrz_dat_sel_a", mux_fwd_rf_a, 2);
`ifdef FWD_HAZARD_STAT_EN
    chk("stat_stall_2", stat_stall_cnt, 2);
`endif
    drain();

    // Asynchronous reset during a stall
    id_set(1, 0, 0, 0, 0, 5, 1, 1);
    tick();
    id_set(1, 5, 0, 1, 0, 0, 0, 0);
    chk("pre_rst_stall", id_stall, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_stall", id_stall, 0);
    chk("async_rst_bubble", ex_bubble, 1);
    chk("async_rst_sel_a", mux_fwd_rf_a, 0);
`ifdef FWD_HAZARD_STAT_EN
    chk("async_rst_stat", stat_stall_cnt, 0);
`endif
    rst_n = 1'b1;
    id_set(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
